// File: rtl/buyruk_onbellek_denetleyici_if.sv
// buyruk_onbellek_denetleyici_if: fetch, cache and memory bus of the instruction cache controller
interface buyruk_onbellek_denetleyici_if;
  logic         getir_istek_i;
  logic [31:0]  getir_adres_i;
  logic         getir_hazir_o;
  logic         iptal_i;
  logic [31:0]  buyruk_o;
  logic         buyruk_gecerli_o;
  logic [31:0]  onbellek_adres_o;
  logic         onbellek_oku_o;
  logic         onbellek_bulundu_i;
  logic [31:0]  onbellek_buyruk_i;
  logic         onbellek_yaz_o;
  logic [127:0] onbellek_obek_o;
  logic         bellek_istek_o;
  logic [31:0]  bellek_adres_o;
  logic         bellek_kabul_i;
  logic [127:0] bellek_obek_i;
  logic         bellek_obek_gecerli_i;
  logic         bellek_hata_o;
  modport master (
    input  getir_istek_i, getir_adres_i, iptal_i, onbellek_bulundu_i, onbellek_buyruk_i,
           bellek_kabul_i, bellek_obek_i, bellek_obek_gecerli_i,
    output getir_hazir_o, buyruk_o, buyruk_gecerli_o, onbellek_adres_o, onbellek_oku_o,
           onbellek_yaz_o, onbellek_obek_o, bellek_istek_o, bellek_adres_o, bellek_hata_o
  );
  modport slave (
    output getir_istek_i, getir_adres_i, iptal_i, onbellek_bulundu_i, onbellek_buyruk_i,
           bellek_kabul_i, bellek_obek_i, bellek_obek_gecerli_i,
    input  getir_hazir_o, buyruk_o, buyruk_gecerli_o, onbellek_adres_o, onbellek_oku_o,
           onbellek_yaz_o, onbellek_obek_o, bellek_istek_o, bellek_adres_o, bellek_hata_o
  );
endinterface

// File: rtl/buyruk_onbellek_denetleyici.sv
// buyruk_onbellek_denetleyici: instruction cache controller with block fill and memory timeout
// BASARIM_SAYAC_EN adds the isabet_sayac_o / iska_sayac_o hit and miss counters
module buyruk_onbellek_denetleyici #(
  parameter int ZAMAN_ASIMI = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef BASARIM_SAYAC_EN
  output logic [31:0] isabet_sayac_o,
  output logic [31:0] iska_sayac_o,
`endif
  buyruk_onbellek_denetleyici_if.master b
);
  typedef enum logic [2:0] {BOSTA, ARA, KONTROL, ISTE, BEKLE, YAZ} durum_t;
  durum_t      durum;
  logic [7:0]  sayac;
  logic        iptal_bayrak;
  logic        yanit_bekliyor;
  logic [31:0] secili;
  always_comb secili = b.bellek_obek_i[{b.onbellek_adres_o[3:2], 5'd0} +: 32];
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      durum                <= BOSTA;
      sayac                <= '0;
      iptal_bayrak         <= 1'b0;
      yanit_bekliyor       <= 1'b0;
      b.getir_hazir_o      <= 1'b0;
      b.buyruk_o           <= '0;
      b.buyruk_gecerli_o   <= 1'b0;
      b.onbellek_adres_o   <= '0;
      b.onbellek_oku_o     <= 1'b0;
      b.onbellek_yaz_o     <= 1'b0;
      b.onbellek_obek_o    <= '0;
      b.bellek_istek_o     <= 1'b0;
      b.bellek_adres_o     <= '0;
      b.bellek_hata_o      <= 1'b0;
    end else begin
      b.onbellek_oku_o   <= 1'b0;
      b.onbellek_yaz_o   <= 1'b0;
      b.bellek_hata_o    <= 1'b0;
      // a hit answers one cycle after KONTROL; a redirect in that cycle still drops it
      b.buyruk_gecerli_o <= yanit_bekliyor && !b.iptal_i;
      yanit_bekliyor     <= 1'b0;
      case (durum)
        BOSTA:
          if (b.getir_hazir_o && b.getir_istek_i && !b.iptal_i) begin
            b.onbellek_adres_o <= b.getir_adres_i;
            b.onbellek_oku_o   <= 1'b1;
            b.getir_hazir_o    <= 1'b0;
            durum              <= ARA;
          end else b.getir_hazir_o <= 1'b1;
        ARA:
          if (b.iptal_i) begin
            b.getir_hazir_o <= 1'b1;
            durum           <= BOSTA;
          end else durum <= KONTROL;
        KONTROL:
          if (b.iptal_i || b.onbellek_bulundu_i) begin
            b.buyruk_o      <= b.onbellek_buyruk_i;
            yanit_bekliyor  <= !b.iptal_i;
            b.getir_hazir_o <= 1'b1;
            durum           <= BOSTA;
          end else begin
            b.bellek_istek_o <= 1'b1;
            b.bellek_adres_o <= {b.onbellek_adres_o[31:4], 4'b0};
            durum            <= ISTE;
          end
        ISTE:
          if (b.bellek_kabul_i) begin
            b.bellek_istek_o <= 1'b0;
            sayac            <= '0;
            iptal_bayrak     <= b.iptal_i;
            durum            <= BEKLE;
          end else if (b.iptal_i) begin
            b.bellek_istek_o <= 1'b0;
            b.getir_hazir_o  <= 1'b1;
            durum            <= BOSTA;
          end
        BEKLE:
          if (b.bellek_obek_gecerli_i) begin
            b.onbellek_yaz_o   <= 1'b1;
            b.onbellek_obek_o  <= b.bellek_obek_i;
            b.buyruk_o         <= secili;
            b.buyruk_gecerli_o <= !(iptal_bayrak || b.iptal_i);
            durum              <= YAZ;
          end else if (sayac == 8'(ZAMAN_ASIMI - 1)) begin
            b.bellek_hata_o <= 1'b1;
            b.getir_hazir_o <= 1'b1;
            iptal_bayrak    <= 1'b0;
            durum           <= BOSTA;
          end else begin
            sayac        <= (&sayac) ? sayac : sayac + 8'd1;
            iptal_bayrak <= iptal_bayrak || b.iptal_i;
          end
        YAZ: begin
          b.getir_hazir_o <= 1'b1;
          iptal_bayrak    <= 1'b0;
          durum           <= BOSTA;
        end
        default: durum <= BOSTA;
      endcase
    end
`ifdef BASARIM_SAYAC_EN
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      isabet_sayac_o <= '0;
      iska_sayac_o   <= '0;
    end else if (durum == KONTROL && !b.iptal_i) begin
      if (b.onbellek_bulundu_i) isabet_sayac_o <= isabet_sayac_o + 32'd1;
      else iska_sayac_o <= iska_sayac_o + 32'd1;
    end
`endif
endmodule

// File: tb/tb_buyruk_onbellek_denetleyici.sv
// tb_buyruk_onbellek_denetleyici: directed and random fetches against an outcome model
module tb_buyruk_onbellek_denetleyici;
  localparam int ZA = 255;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;
  buyruk_onbellek_denetleyici_if u ();
`ifdef BASARIM_SAYAC_EN
  logic [31:0] isabet, iska;
`endif
  buyruk_onbellek_denetleyici #(.ZAMAN_ASIMI(ZA)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
`ifdef BASARIM_SAYAC_EN
    .isabet_sayac_o(isabet),
    .iska_sayac_o(iska),
`endif
    .b(u.master)
  );

  int n_chk = 0, n_err = 0;
  int cyc = 0, n_gec = 0, n_yaz = 0, n_hata = 0, n_istek = 0, gec_cyc = 0;
  logic [31:0] son_buyruk = '0;

  always @(posedge clk_i) cyc <= cyc + 1;
  always @(negedge clk_i) begin
    if (u.buyruk_gecerli_o === 1'b1) begin
      n_gec      <= n_gec + 1;
      son_buyruk <= u.buyruk_o;
      gec_cyc    <= cyc;
    end
    if (u.onbellek_yaz_o === 1'b1) n_yaz <= n_yaz + 1;
    if (u.bellek_hata_o === 1'b1) n_hata <= n_hata + 1;
    if (u.bellek_istek_o === 1'b1) n_istek <= n_istek + 1;
  end

  task automatic chk(input string t, input logic [127:0] g, input logic [127:0] e);
    n_chk++;
    assert (g === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", t, g, e);
    end
  endtask

  task automatic cevrim();
    @(negedge clk_i);
    #1;
  endtask

  // pt: 0 none, 1 ARA, 2 KONTROL, 3 ISTE before accept, 4 with accept, 5 in BEKLE
  // v: BEKLE cycles before the block arrives; v >= ZA means it never arrives
  task automatic islem(input logic [31:0] a, input bit hit, input logic [31:0] hw,
                       input int d, input int v, input int pt, input logic [127:0] blk);
    bit istek_var, fill, tout, resp;
    int ta, g0, y0, h0, i0, gecikme;
    logic [31:0] w, hizali;
    istek_var = !hit && pt != 1 && pt != 2;
    fill      = istek_var && pt != 3 && v < ZA;
    tout      = istek_var && pt != 3 && v >= ZA;
    resp      = hit ? pt == 0 : fill && pt == 0;
    w         = hit ? hw : 32'(blk >> (32 * a[3:2]));
    hizali    = a & 32'hFFFF_FFF0;
    gecikme   = hit ? 3 : 4 + d + v;
    g0 = n_gec; y0 = n_yaz; h0 = n_hata; i0 = n_istek;
    chk("hazir", 128'(u.getir_hazir_o), 128'(1));
    u.getir_istek_i = 1'b1;
    u.getir_adres_i = a;
    cevrim();
    ta = cyc;
    u.getir_istek_i = 1'b0;
    u.getir_adres_i = $urandom;
    chk("oku", 128'(u.onbellek_oku_o), 128'(1));
    chk("hazir_mesgul", 128'(u.getir_hazir_o), 128'(0));
    chk("onbellek_adres", 128'(u.onbellek_adres_o), 128'(a));
    u.iptal_i = pt == 1;
    cevrim();
    u.iptal_i = 1'b0;
    chk("oku_tek", 128'(u.onbellek_oku_o), 128'(0));
    if (pt == 1) chk("iptal_ara_hazir", 128'(u.getir_hazir_o), 128'(1));
    else begin
      u.onbellek_bulundu_i = hit;
      u.onbellek_buyruk_i  = hw;
      u.iptal_i            = pt == 2;
      cevrim();
      u.onbellek_bulundu_i = 1'b0;
      u.onbellek_buyruk_i  = $urandom;
      u.iptal_i            = 1'b0;
      if (!istek_var) begin
        chk("kontrol_hazir", 128'(u.getir_hazir_o), 128'(1));
        chk("gecerli_erken", 128'(u.buyruk_gecerli_o), 128'(0));
        chk("istek_yok", 128'(u.bellek_istek_o), 128'(0));
      end else begin
        for (int k = 0; k < d; k++) begin
          chk("istek", 128'(u.bellek_istek_o), 128'(1));
          chk("bellek_adres", 128'(u.bellek_adres_o), 128'(hizali));
          u.iptal_i = pt == 3 && k == d - 1;
          cevrim();
          u.iptal_i = 1'b0;
        end
        if (pt == 3) begin
          chk("iptal_iste_istek", 128'(u.bellek_istek_o), 128'(0));
          chk("iptal_iste_hazir", 128'(u.getir_hazir_o), 128'(1));
        end else begin
          chk("istek_kabul", 128'(u.bellek_istek_o), 128'(1));
          chk("bellek_adres_kabul", 128'(u.bellek_adres_o), 128'(hizali));
          u.bellek_kabul_i = 1'b1;
          u.iptal_i        = pt == 4;
          cevrim();
          u.bellek_kabul_i = 1'b0;
          u.iptal_i        = 1'b0;
          chk("istek_dusuk", 128'(u.bellek_istek_o), 128'(0));
          for (int c = 0; c < ZA && c <= v; c++) begin
            u.bellek_obek_gecerli_i = c == v;
            u.bellek_obek_i         = blk;
            u.iptal_i               = pt == 5 && c == v / 2;
            cevrim();
            u.bellek_obek_gecerli_i = 1'b0;
            u.bellek_obek_i         = {4{$urandom}};
            u.iptal_i               = 1'b0;
          end
          if (fill) begin
            chk("yaz", 128'(u.onbellek_yaz_o), 128'(1));
            chk("obek", u.onbellek_obek_o, blk);
            chk("yaz_gecerli", 128'(u.buyruk_gecerli_o), 128'(resp));
            cevrim();
            chk("yaz_tek", 128'(u.onbellek_yaz_o), 128'(0));
            chk("yaz_hazir", 128'(u.getir_hazir_o), 128'(1));
          end else begin
            chk("hata", 128'(u.bellek_hata_o), 128'(1));
            chk("hata_hazir", 128'(u.getir_hazir_o), 128'(1));
            chk("hata_yaz", 128'(u.onbellek_yaz_o), 128'(0));
          end
        end
      end
    end
    repeat (3) cevrim();
    chk("gecerli_sayi", 128'(n_gec - g0), 128'(resp));
    chk("yaz_sayi", 128'(n_yaz - y0), 128'(fill));
    chk("hata_sayi", 128'(n_hata - h0), 128'(tout));
    chk("istek_cevrim", 128'(n_istek - i0), 128'(pt == 3 ? d : istek_var ? d + 1 : 0));
    if (resp) begin
      chk("buyruk", 128'(son_buyruk), 128'(w));
      chk("gecikme", 128'(gec_cyc - ta), 128'(gecikme));
    end
  endtask

  logic [127:0] blk4 = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
  int y0, g0;

  initial begin
    u.getir_istek_i = 0; u.getir_adres_i = 0; u.iptal_i = 0;
    u.onbellek_bulundu_i = 0; u.onbellek_buyruk_i = 0;
    u.bellek_kabul_i = 0; u.bellek_obek_i = 0; u.bellek_obek_gecerli_i = 0;
    #2 rst_i = 1'b0;
    #1;
    chk("sifir_cikis", 128'({u.getir_hazir_o, u.buyruk_o, u.buyruk_gecerli_o, u.onbellek_adres_o,
        u.onbellek_oku_o, u.onbellek_yaz_o, u.bellek_istek_o, u.bellek_adres_o, u.bellek_hata_o}), 128'(0));
    chk("sifir_obek", u.onbellek_obek_o, 128'(0));
    repeat (2) cevrim();
    rst_i = 1'b1;
    cevrim();

    islem(32'h0000_1008, 1, 32'hDEAD_BEEF, 0, 0, 0, '0);
    islem(32'h0000_200C, 0, 32'h0, 0, 2, 0, blk4);
    islem(32'h0000_3004, 0, 32'h0, 5, 1, 0, blk4);
    islem(32'h0000_4008, 0, 32'h0, 1, 3, 5, blk4);
    islem(32'h0000_5000, 0, 32'h0, 0, ZA, 0, blk4);
    islem(32'h0000_6008, 0, 32'h0, 0, ZA - 1, 0, blk4);
    islem(32'h0000_7000, 0, 32'h0, 0, 0, 1, blk4);
    islem(32'h0000_8000, 1, 32'h1234_5678, 0, 0, 2, blk4);
    islem(32'h0000_9004, 0, 32'h0, 2, 0, 3, blk4);
    islem(32'h0000_A00C, 0, 32'h0, 1, 0, 4, blk4);

    // a request coinciding with a redirect is not taken
    u.getir_istek_i = 1'b1; u.iptal_i = 1'b1;
    cevrim();
    u.getir_istek_i = 1'b0; u.iptal_i = 1'b0;
    chk("iptal_bosta_oku", 128'(u.onbellek_oku_o), 128'(0));
    chk("iptal_bosta_hazir", 128'(u.getir_hazir_o), 128'(1));

    // reset in BEKLE, then a late block
    y0 = n_yaz; g0 = n_gec;
    u.getir_istek_i = 1'b1; u.getir_adres_i = 32'h0000_B004;
    cevrim();
    u.getir_istek_i = 1'b0;
    repeat (2) cevrim();
    u.bellek_kabul_i = 1'b1;
    cevrim();
    u.bellek_kabul_i = 1'b0;
    cevrim();
    rst_i = 1'b0;
    #1;
    chk("rst_bekle_cikis", 128'({u.getir_hazir_o, u.buyruk_o, u.buyruk_gecerli_o, u.onbellek_adres_o,
        u.onbellek_oku_o, u.onbellek_yaz_o, u.bellek_istek_o, u.bellek_adres_o, u.bellek_hata_o}), 128'(0));
    u.bellek_obek_gecerli_i = 1'b1; u.bellek_obek_i = blk4;
    cevrim();
    rst_i = 1'b1;
    cevrim();
    u.bellek_obek_gecerli_i = 1'b0;
    cevrim();
    chk("rst_sonra_cikis", 128'({u.buyruk_o, u.buyruk_gecerli_o, u.onbellek_adres_o, u.onbellek_oku_o,
        u.onbellek_yaz_o, u.bellek_istek_o, u.bellek_adres_o, u.bellek_hata_o}), 128'(0));
    chk("rst_sonra_obek", u.onbellek_obek_o, 128'(0));
    chk("rst_sonra_hazir", 128'(u.getir_hazir_o), 128'(1));
    chk("rst_yaz_sayi", 128'(n_yaz - y0), 128'(0));
    chk("rst_gecerli_sayi", 128'(n_gec - g0), 128'(0));

    for (int i = 0; i < 60; i++) begin
      bit h;
      int pt, d, v;
      logic [127:0] blk;
      h  = 1'($urandom_range(0, 1));
      pt = int'($urandom_range(0, 7));
      if (pt > 5 || (h && pt > 2)) pt = 0;
      d  = int'($urandom_range(pt == 3 ? 1 : 0, 4));
      v  = ($urandom_range(0, 15) == 0) ? ZA : int'($urandom_range(0, 6));
      blk = {$urandom, $urandom, $urandom, $urandom};
      islem($urandom, h, $urandom, d, v, pt, blk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
